// File: rtl/fft_butterfly_if.sv
// Bundle of the butterfly's data, handshake and twiddle-ROM signals.
// The slave modport is the butterfly's view; the master modport is the view of
// whatever feeds it and also owns the twiddle ROM.
interface fft_butterfly_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int TWIDDLE_WIDTH = 16,
   parameter int ADDR_WIDTH    = 9
);
   logic                            stall;
   logic                            in_valid;
   logic signed [DATA_WIDTH-1:0]    a_re, a_im, b_re, b_im;
   logic        [ADDR_WIDTH-1:0]    twiddle_index;
   logic                            scale;
   logic        [ADDR_WIDTH-1:0]    twiddle_address;
   logic signed [TWIDDLE_WIDTH-1:0] real_twiddle, imag_twiddle;
   logic                            out_valid;
   logic signed [DATA_WIDTH-1:0]    y0_re, y0_im, y1_re, y1_im;
   logic                            clear_overflow;
   logic                            overflow;

   modport slave (
      input  stall, in_valid, a_re, a_im, b_re, b_im, twiddle_index, scale,
             real_twiddle, imag_twiddle, clear_overflow,
      output twiddle_address, out_valid, y0_re, y0_im, y1_re, y1_im, overflow
   );

   modport master (
      output stall, in_valid, a_re, a_im, b_re, b_im, twiddle_index, scale,
             real_twiddle, imag_twiddle, clear_overflow,
      input  twiddle_address, out_valid, y0_re, y0_im, y1_re, y1_im, overflow
   );
endinterface

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: Y0 = A + B*W, Y1 = A - B*W.
// Four-stage pipeline (accept, multiply, round, add/saturate) at one pair per
// cycle.  The twiddle ROM is registered, so the address is presented
// combinationally in the accept cycle and the ROM data lines up with stage 2.
// A global stall freezes every stage and holds the ROM address.
module fft_butterfly #(
   parameter int DATA_WIDTH    = 16,
   parameter int TWIDDLE_WIDTH = 16,
   parameter int ADDR_WIDTH    = 9
) (
   input  logic            clock,
   input  logic            reset,
   fft_butterfly_if.slave  bus
);
   localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;   // full product width
   localparam int SW = DATA_WIDTH + 2;               // twiddled/sum width
   localparam int FB = TWIDDLE_WIDTH - 2;            // twiddle fraction bits
   localparam logic signed [PW:0] RND = (PW+1)'(1) << (TWIDDLE_WIDTH-3);

   logic                          w_accept;
   logic [4:1]                    r_vld;
   logic [ADDR_WIDTH-1:0]         r_addr;

   logic signed [DATA_WIDTH-1:0]  r_a1_re, r_a1_im, r_b1_re, r_b1_im;
   logic signed [DATA_WIDTH-1:0]  r_a2_re, r_a2_im, r_a3_re, r_a3_im;
   logic                          r_sc1, r_sc2, r_sc3;
   logic signed [PW-1:0]          r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic signed [PW:0]            w_t_re, w_t_im;
   logic signed [SW-1:0]          r_t_re, r_t_im;
   logic signed [SW-1:0]          w_a_re, w_a_im;
   logic signed [SW-1:0]          w_sum [4];
   logic        [DATA_WIDTH:0]    w_sat [4];
   logic                          w_any_sat;
   logic signed [DATA_WIDTH-1:0]  r_y [4];
   logic                          r_ovf;

   // Clamp a stage-4 sum to DATA_WIDTH; MSB of the result flags a clamp.
   function automatic logic [DATA_WIDTH:0] sat(input logic [SW-1:0] v);
      logic fits;
      fits = (&v[SW-1:DATA_WIDTH-1]) | ~(|v[SW-1:DATA_WIDTH-1]);
      if (fits) sat = {1'b0, v[DATA_WIDTH-1:0]};
      else      sat = {1'b1, v[SW-1], {(DATA_WIDTH-1){~v[SW-1]}}};
   endfunction

   assign w_accept = bus.in_valid & ~bus.stall;

   // Remember the last accepted index so the ROM keeps re-reading it while idle or stalled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        r_addr <= '0;
      else if (w_accept) r_addr <= bus.twiddle_index;
   end

   assign bus.twiddle_address = !reset ? '0 : (w_accept ? bus.twiddle_index : r_addr);

   // Valid shift register; bubbles travel as zeros.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           r_vld <= '0;
      else if (!bus.stall)  r_vld <= {r_vld[3:1], bus.in_valid};
   end

   // Stage 1: capture operands.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_a1_re <= '0; r_a1_im <= '0; r_b1_re <= '0; r_b1_im <= '0; r_sc1 <= 1'b0;
      end else if (!bus.stall) begin
         r_a1_re <= bus.a_re; r_a1_im <= bus.a_im;
         r_b1_re <= bus.b_re; r_b1_im <= bus.b_im;
         r_sc1   <= bus.scale;
      end
   end

   // Stage 2: four full-width products against the ROM data of this cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_p_rr <= '0; r_p_ii <= '0; r_p_ri <= '0; r_p_ir <= '0;
         r_a2_re <= '0; r_a2_im <= '0; r_sc2 <= 1'b0;
      end else if (!bus.stall) begin
         r_p_rr  <= PW'(r_b1_re) * PW'(bus.real_twiddle);
         r_p_ii  <= PW'(r_b1_im) * PW'(bus.imag_twiddle);
         r_p_ri  <= PW'(r_b1_re) * PW'(bus.imag_twiddle);
         r_p_ir  <= PW'(r_b1_im) * PW'(bus.real_twiddle);
         r_a2_re <= r_a1_re; r_a2_im <= r_a1_im;
         r_sc2   <= r_sc1;
      end
   end

   assign w_t_re = (PW+1)'(r_p_rr) - (PW+1)'(r_p_ii) + RND;
   assign w_t_im = (PW+1)'(r_p_ri) + (PW+1)'(r_p_ir) + RND;

   // Stage 3: round-half-up and drop the twiddle fraction bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_t_re <= '0; r_t_im <= '0; r_a3_re <= '0; r_a3_im <= '0; r_sc3 <= 1'b0;
      end else if (!bus.stall) begin
         r_t_re  <= SW'(w_t_re >>> FB);
         r_t_im  <= SW'(w_t_im >>> FB);
         r_a3_re <= r_a2_re; r_a3_im <= r_a2_im;
         r_sc3   <= r_sc2;
      end
   end

   assign w_a_re = SW'(r_a3_re);
   assign w_a_im = SW'(r_a3_im);

   // Butterfly add/sub, optional halving, saturation to DATA_WIDTH.
   always_comb begin
      w_any_sat = 1'b0;
      w_sum[0]  = w_a_re + r_t_re;
      w_sum[1]  = w_a_im + r_t_im;
      w_sum[2]  = w_a_re - r_t_re;
      w_sum[3]  = w_a_im - r_t_im;
      for (int i = 0; i < 4; i++) begin
         if (r_sc3) w_sum[i] = w_sum[i] >>> 1;
         w_sat[i]  = sat(w_sum[i]);
         w_any_sat = w_any_sat | w_sat[i][DATA_WIDTH];
      end
   end

   // Stage 4: output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) r_y[i] <= '0;
      end else if (!bus.stall) begin
         for (int i = 0; i < 4; i++) r_y[i] <= w_sat[i][DATA_WIDTH-1:0];
      end
   end

   // Sticky overflow: only valid slots set it, and a set beats a same-cycle clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                  r_ovf <= 1'b0;
      else if (!bus.stall && r_vld[3] && w_any_sat) r_ovf <= 1'b1;
      else if (bus.clear_overflow)                 r_ovf <= 1'b0;
   end

   assign bus.out_valid = r_vld[4];
   assign bus.y0_re     = r_y[0];
   assign bus.y0_im     = r_y[1];
   assign bus.y1_re     = r_y[2];
   assign bus.y1_im     = r_y[3];
   assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: a stimulus process pushes hand-computed
// results into a queue, a monitor pops and compares on every consumed output.
module tb_fft_butterfly;
   logic clock = 1'b0;
   logic reset;

   fft_butterfly_if #(.DATA_WIDTH(16), .TWIDDLE_WIDTH(16), .ADDR_WIDTH(9)) bus ();

   fft_butterfly #(.DATA_WIDTH(16), .TWIDDLE_WIDTH(16), .ADDR_WIDTH(9)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Registered twiddle ROM: 0 -> 1, 1 -> -j, 2 -> (1-j)/sqrt2, 3 -> -1.
   logic signed [15:0] rom_re [4] = '{16384, 0, 11585, -16384};
   logic signed [15:0] rom_im [4] = '{0, -16384, -11585, 0};
   initial begin
      bus.real_twiddle = '0;
      bus.imag_twiddle = '0;
   end
   always @(posedge clock) begin
      bus.real_twiddle <= rom_re[bus.twiddle_address[1:0]];
      bus.imag_twiddle <= rom_im[bus.twiddle_address[1:0]];
   end

   typedef struct {
      int y0r, y0i, y1r, y1i;
      int ovf;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Monitor: one pop per output consumed in a non-stalled cycle.
   always @(negedge clock) begin
      if (reset && bus.out_valid && !bus.stall) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out_valid: got y0=(%0d,%0d) y1=(%0d,%0d), expected no output",
                     bus.y0_re, bus.y0_im, bus.y1_re, bus.y1_im);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (int'(bus.y0_re) != e.y0r || int'(bus.y0_im) != e.y0i ||
                int'(bus.y1_re) != e.y1r || int'(bus.y1_im) != e.y1i ||
                int'(bus.overflow) != e.ovf) begin
               n_err++;
               $display("FAIL result: got y0=(%0d,%0d) y1=(%0d,%0d) ovf=%0d, expected y0=(%0d,%0d) y1=(%0d,%0d) ovf=%0d",
                        bus.y0_re, bus.y0_im, bus.y1_re, bus.y1_im, bus.overflow,
                        e.y0r, e.y0i, e.y1r, e.y1i, e.ovf);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) step();
   endtask

   // Drive one pair for one cycle and push its expected result.
   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input int idx, input int sc,
                       input int y0r, input int y0i, input int y1r, input int y1i,
                       input int ovf);
      exp_t e;
      bus.in_valid      = 1'b1;
      bus.a_re          = 16'(ar);
      bus.a_im          = 16'(ai);
      bus.b_re          = 16'(br);
      bus.b_im          = 16'(bi);
      bus.twiddle_index = 9'(idx);
      bus.scale         = sc[0];
      e.y0r = y0r; e.y0i = y0i; e.y1r = y1r; e.y1i = y1i; e.ovf = ovf;
      q.push_back(e);
      step();
   endtask

   initial begin
      reset              = 1'b0;
      bus.stall          = 1'b0;
      bus.in_valid       = 1'b0;
      bus.a_re           = '0;
      bus.a_im           = '0;
      bus.b_re           = '0;
      bus.b_im           = '0;
      bus.twiddle_index  = '0;
      bus.scale          = 1'b0;
      bus.clear_overflow = 1'b0;
      repeat (2) step();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_y0_re", int'(bus.y0_re), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_twiddle_address", int'(bus.twiddle_address), 0);

      // Release and accept on the very first edge afterwards.
      reset = 1'b1;
      send(100, 50, 20, -10, 0, 0, 120, 40, 80, 60, 0);
      idle(6);
      send(100, 50, 20, -10, 1, 0, 90, 30, 110, 70, 0);
      idle(6);
      send(100, 50, 20, -10, 0, 1, 60, 20, 40, 30, 0);
      idle(6);

      // Positive saturation, sticky flag, clear.
      send(32767, 0, 32767, 0, 0, 0, 32767, 0, 0, 0, 1);
      idle(6);
      chk("ovf_sticky", int'(bus.overflow), 1);
      idle(3);
      chk("ovf_sticky_later", int'(bus.overflow), 1);
      bus.clear_overflow = 1'b1;
      step();
      bus.clear_overflow = 1'b0;
      chk("ovf_cleared", int'(bus.overflow), 0);
      // Saturating operands keep flowing as bubbles; they must not set the flag.
      idle(8);
      chk("ovf_bubble_sat", int'(bus.overflow), 0);

      // Back-to-back stream with a 3-cycle stall right after the 4th accept.
      send(100, 50, 20, -10, 0, 0, 120, 40, 80, 60, 0);
      send(100, 50, 20, -10, 1, 0, 90, 30, 110, 70, 0);
      send(0, 0, 100, 0, 2, 0, 71, -71, -71, 71, 0);
      send(10, 20, 5, 6, 3, 0, 5, 14, 15, 26, 0);
      bus.stall         = 1'b1;
      bus.in_valid      = 1'b1;
      bus.a_re          = 16'sd999;
      bus.b_re          = 16'sd999;
      bus.twiddle_index = 9'd2;
      repeat (3) begin
         #2;
         chk("stall_addr_hold", int'(bus.twiddle_address), 3);
         step();
      end
      bus.stall = 1'b0;
      send(-100, -200, -20, 30, 0, 0, -120, -170, -80, -230, 0);
      send(1000, -1000, 300, 400, 1, 0, 1400, -1300, 600, -700, 0);
      send(7, 3, 2, 0, 0, 1, 4, 1, 2, 1, 0);
      send(-5, -1, 0, 0, 0, 1, -3, -1, -3, -1, 0);
      idle(8);

      // Negative saturation while clear is held: set wins.
      bus.clear_overflow = 1'b1;
      send(-32768, -32768, 1, 1, 3, 0, -32768, -32768, -32767, -32767, 1);
      idle(6);
      bus.clear_overflow = 1'b0;
      chk("ovf_clear_after_set", int'(bus.overflow), 0);

      // Reset with three pairs in flight.
      send(100, 50, 20, -10, 0, 0, 120, 40, 80, 60, 0);
      send(100, 50, 20, -10, 1, 0, 90, 30, 110, 70, 0);
      send(0, 0, 100, 0, 2, 0, 71, -71, -71, 71, 0);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_y0_re", int'(bus.y0_re), 0);
      chk("midrst_y1_im", int'(bus.y1_im), 0);
      chk("midrst_twiddle_address", int'(bus.twiddle_address), 0);
      q.delete();
      repeat (2) step();
      reset = 1'b1;
      send(100, 50, 20, -10, 1, 0, 90, 30, 110, 70, 0);
      idle(10);

      begin
         int budget;
         budget = 50;
         while (q.size() != 0 && budget > 0) begin
            step();
            budget--;
         end
      end
      chk("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fft_butterfly.md
FFT_BUTTERFLY -- requirements
Module: fft_butterfly

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of signed complex sample parts.
REQ-002 SHALL have parameter TWIDDLE_WIDTH, default 16, width of signed twiddle parts; Q2.(TWIDDLE_WIDTH-2), so 1.0 = 2^(TWIDDLE_WIDTH-2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, width of twiddle address.
REQ-004 Ports (name, direction, width, meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; low = reset.
- stall  in  1  freeze entire pipeline.
- in_valid  in  1  input operands valid this cycle.
- a_re, a_im, b_re, b_im  in  DATA_WIDTH  signed butterfly inputs A, B.
- twiddle_index  in  ADDR_WIDTH  twiddle ROM index for this pair.
- scale  in  1  halve outputs for this pair.
- twiddle_address  out  ADDR_WIDTH  to twiddle ROM; ROM returns registered data one cycle later.
- real_twiddle, imag_twiddle  in  TWIDDLE_WIDTH  signed twiddle from ROM.
- out_valid  out  1  results valid.
- y0_re, y0_im, y1_re, y1_im  out  DATA_WIDTH  signed results.
- clear_overflow  in  1  synchronous clear of overflow.
- overflow  out  1  sticky saturation flag.

Function
REQ-005 SHALL compute T = B*W, Y0 = A+T, Y1 = A-T (radix-2 DIT), full throughput: one pair per cycle when not stalled.
REQ-006 SHALL drive twiddle_address = twiddle_index when in_valid=1 and stall=0; otherwise SHALL hold the last driven address.
REQ-007 Stage 1 (accept): SHALL register A, B, scale, valid.
REQ-008 Stage 2: SHALL register the four products b_re*wr, b_im*wi, b_re*wi, b_im*wr at full width (DATA_WIDTH+TWIDDLE_WIDTH), using twiddle data that arrives this cycle.
REQ-009 Stage 3: SHALL form t_re = p_rr - p_ii, t_im = p_ri + p_ir, add rounding constant 2^(TWIDDLE_WIDTH-3), arithmetic-shift right by TWIDDLE_WIDTH-2, keep DATA_WIDTH+2 bits, register.
REQ-010 Stage 4: SHALL compute A±T at DATA_WIDTH+2 bits; if scale=1 SHALL arithmetic-shift right by 1 (truncate); SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; SHALL register outputs.
REQ-011 Latency SHALL be exactly 4 non-stalled cycles from in_valid to out_valid for the same pair.
REQ-012 out_valid SHALL be high for exactly one non-stalled cycle per accepted pair; bubbles SHALL propagate as out_valid=0.
REQ-013 When stall=1, all pipeline registers, out_valid and outputs SHALL hold; inputs SHALL be ignored; twiddle_address SHALL hold so ROM output stays stable.
REQ-014 A stall asserted the cycle after an accept SHALL NOT corrupt that pair's twiddle (address held, ROM re-reads same entry).
REQ-015 overflow SHALL set on any cycle where an output part saturates while the stage-4 register loads with valid data; it SHALL stay set until clear_overflow=1.
REQ-016 If clear_overflow and a new saturation coincide, overflow SHALL end the cycle at 1 (set wins).
REQ-017 Saturation on an invalid (bubble) slot SHALL NOT set overflow.

Reset
REQ-018 While reset=0, all valid bits, out_valid, overflow, twiddle_address and all data outputs SHALL be 0, immediately (asynchronously).
REQ-019 A pair in flight when reset asserts SHALL be discarded; no out_valid SHALL appear for it after release.
REQ-020 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-021 W=(16384,0), A=(100,50), B=(20,-10), scale=0 -> 4 cycles later out_valid=1, Y0=(120,40), Y1=(80,60), overflow=0.
REQ-022 W=(0,-16384), same A, B -> T=(-10,-20), Y0=(90,30), Y1=(110,70).
REQ-023 W=(16384,0), A=(100,50), B=(20,-10), scale=1 -> Y0=(60,20), Y1=(40,30).
REQ-024 W=(16384,0), A=(32767,0), B=(32767,0) -> Y0_re=32767, Y1_re=0, overflow=1 sticky until clear_overflow pulse, then 0.
REQ-025 Back-to-back 8 pairs with stall=1 for 3 cycles mid-stream -> all 8 results correct, in order, each exactly once; twiddle_address constant during stall.
REQ-026 reset pulsed low with 3 pairs in flight -> outputs 0 immediately; no out_valid after release until new pairs accepted.
